// File: rtl/bus_master_if.sv
// bus_master_if: command/response stream plus register bus wiring.
// master = bus_master side, slave = command source and bus fabric side.
interface bus_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wr_data;
  logic                  bus_rd_req;
  logic                  bus_wr_req;
  logic [DATA_WIDTH-1:0] bus_rd_data;
  logic                  bus_rd_ack;
  logic                  bus_wr_ack;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  bus_rd_data, bus_rd_ack, bus_wr_ack,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output bus_addr, bus_wr_data, bus_rd_req, bus_wr_req
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready,
    output bus_rd_data, bus_rd_ack, bus_wr_ack,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  bus_addr, bus_wr_data, bus_rd_req, bus_wr_req
  );
endinterface

// File: rtl/bus_master.sv
// bus_master: single-outstanding register bus initiator.
// Turns one command into one request pulse and one response.
module bus_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic         bus_clk,
  input logic         bus_reset,
  bus_master_if.master bif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } state_t;

  state_t          state;
  state_t          next;
  logic            armed;
  logic            wr_q;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            hit;
  logic            expire;

  assign bif.cmd_ready = (state == IDLE) && armed;
  assign accept = bif.cmd_valid && bif.cmd_ready;
  assign hit    = wr_q ? bif.bus_wr_ack : bif.bus_rd_ack;
  assign expire = (cnt == CNT_MAX);

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Next-state decode; acks outside WAIT fall through unused.
  always_comb begin
    next = state;
    unique case (state)
      IDLE: if (accept) next = REQ;
      REQ:  next = WAIT;
      WAIT: if (hit || expire) next = RSP;
      RSP:  if (bif.rsp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Datapath: latch command, pulse request, watch ack, hold response.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      armed           <= 1'b0;
      wr_q            <= 1'b0;
      cnt             <= '0;
      bif.bus_addr    <= '0;
      bif.bus_wr_data <= '0;
      bif.bus_rd_req  <= 1'b0;
      bif.bus_wr_req  <= 1'b0;
      bif.rsp_valid   <= 1'b0;
      bif.rsp_rdata   <= '0;
      bif.rsp_err     <= 1'b0;
    end else begin
      armed          <= 1'b1;
      bif.bus_rd_req <= 1'b0;
      bif.bus_wr_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_q            <= bif.cmd_write;
            bif.bus_addr    <= bif.cmd_addr;
            bif.bus_wr_data <= bif.cmd_wdata;
          end
        end
        REQ: begin
          bif.bus_wr_req <= wr_q;
          bif.bus_rd_req <= !wr_q;
          cnt            <= '0;
        end
        WAIT: begin
          if (hit) begin
            bif.rsp_valid <= 1'b1;
            bif.rsp_err   <= 1'b0;
            bif.rsp_rdata <= wr_q ? '0 : bif.bus_rd_data;
          end else if (expire) begin
            bif.rsp_valid <= 1'b1;
            bif.rsp_err   <= 1'b1;
            bif.rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RSP: begin
          if (bif.rsp_ready) bif.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
